// File: rtl/step_seq_pkg.sv
// -----------------------------------------------------------------------------
// step_seq_pkg
// Shared definitions for the step sequencer:
//   - state_t      : sequencer state (IDLE, PLAY)
//   - TIME_W       : width of the step_period / gate_len / swing inputs
//   - LEN_W        : internal step-length width (one bit of headroom so that
//                    P plus a swing extension cannot overflow)
//   - clamp_period : P = max(step_period, 2)
//   - clamp_gate   : G = min(gate_len, step_length - 1)
//   - clamp_swing  : S = min(swing, P/2 - 1)
// -----------------------------------------------------------------------------
package step_seq_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        PLAY = 1'b1
    } state_t;

    localparam int TIME_W = 24;
    localparam int LEN_W  = TIME_W + 1;

    function automatic logic [LEN_W-1:0] clamp_period(input logic [TIME_W-1:0] p);
        logic [LEN_W-1:0] pw;
        pw = {1'b0, p};
        return (pw < LEN_W'(2)) ? LEN_W'(2) : pw;
    endfunction

    // The gate always drops at least one cycle before the step ends so that
    // downstream envelopes see a fresh rising edge on every note.
    function automatic logic [LEN_W-1:0] clamp_gate(input logic [TIME_W-1:0] g,
                                                    input logic [LEN_W-1:0]  len);
        logic [LEN_W-1:0] gw;
        gw = {1'b0, g};
        return (gw < len) ? gw : len - LEN_W'(1);
    endfunction

    // p is already clamped to >= 2, so the limit never underflows and an
    // odd (shortened) step keeps at least P/2 + 1 >= 2 cycles.
    function automatic logic [LEN_W-1:0] clamp_swing(input logic [TIME_W-1:0] s,
                                                     input logic [LEN_W-1:0]  p);
        logic [LEN_W-1:0] lim;
        logic [LEN_W-1:0] sw;
        lim = (p >> 1) - LEN_W'(1);
        sw  = {1'b0, s};
        return (sw < lim) ? sw : lim;
    endfunction

endpackage

// File: rtl/seq_step_timer.sv
// -----------------------------------------------------------------------------
// seq_step_timer
// Per-step cycle counter for the step sequencer. Step length and gate length
// are sampled when a step starts and held for the whole step.
// Optional feature: define STEP_SEQ_SWING_EN to add the swing input; even
// steps are then lengthened and odd steps shortened by the clamped swing.
//
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   clear        : forces the counter back to 0 (sequencer stopped)
//   start        : this edge begins a new step (counter to 0, sample P/G/S)
//   count        : advance the counter on this edge
//   step_period  : requested clocks per step (clamped to >= 2)
//   gate_len     : requested gate-high clocks (clamped to length - 1)
//   step_odd     : (swing only) parity of the step being entered
//   swing        : (swing only) requested swing in clocks
//   step_end     : counter is on the last cycle of the current step
//   gate_on      : gate level for the cycle that follows this edge
// -----------------------------------------------------------------------------
module seq_step_timer
    import step_seq_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              start,
    input  logic              count,
    input  logic [TIME_W-1:0] step_period,
    input  logic [TIME_W-1:0] gate_len,
`ifdef STEP_SEQ_SWING_EN
    input  logic              step_odd,
    input  logic [TIME_W-1:0] swing,
`endif
    output logic              step_end,
    output logic              gate_on
);

    logic [LEN_W-1:0] cnt;
    logic [LEN_W-1:0] len_lat;
    logic [LEN_W-1:0] g_lat;
    logic [LEN_W-1:0] p_new;
    logic [LEN_W-1:0] len_new;
    logic [LEN_W-1:0] g_new;
`ifdef STEP_SEQ_SWING_EN
    logic [LEN_W-1:0] s_new;
`endif

    always_comb begin
        p_new = clamp_period(step_period);
`ifdef STEP_SEQ_SWING_EN
        s_new   = clamp_swing(swing, p_new);
        len_new = step_odd ? (p_new - s_new) : (p_new + s_new);
`else
        len_new = p_new;
`endif
        g_new = clamp_gate(gate_len, len_new);
    end

    assign step_end = (cnt == (len_lat - LEN_W'(1)));

    // Look-ahead: on a start edge the gate depends on the freshly sampled G,
    // otherwise it stays high while the next count value is still below G.
    assign gate_on = start ? (g_new != '0) : ((cnt + LEN_W'(1)) < g_lat);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt <= '0;
        end else if (start) begin
            cnt <= '0;
        end else if (count) begin
            cnt <= cnt + LEN_W'(1);
        end
    end

    // Step length and gate length are only consumed while playing, after a
    // start edge has loaded them, so they carry no reset.
    always_ff @(posedge clk) begin
        if (start) begin
            len_lat <= len_new;
            g_lat   <= g_new;
        end
    end

endmodule

// File: rtl/step_sequencer.sv
// -----------------------------------------------------------------------------
// step_sequencer
// Multi-voice pattern player. Holds a NUM_VOICES x NUM_STEPS pattern of
// {freq, on} cells and, while run is high, steps through it at a runtime
// tempo, driving registered tone_freq / gate words for the voice channels.
// Optional feature: define STEP_SEQ_SWING_EN to add the swing input.
//
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   run          : level, high = play, low = stop (restart is from step 0)
//   step_period  : clocks per step (values < 2 act as 2)
//   gate_len     : clocks the gate stays high at the start of each step
//   last_step    : last step of the loop before wrapping to 0
//   swing        : (swing only) even steps +S, odd steps -S clocks
//   wr_en        : pattern write strobe
//   wr_voice     : voice of the cell being written
//   wr_step      : step of the cell being written
//   wr_freq      : frequency word written
//   wr_on        : note-on flag written
//   tone_freq    : voice v at bits [v*FREQ_BITS +: FREQ_BITS]
//   gate         : per-voice gate
//   step_idx     : current step
//   step_strobe  : one-cycle pulse on the first cycle of every step
// -----------------------------------------------------------------------------
module step_sequencer
    import step_seq_pkg::*;
#(
    parameter int NUM_VOICES = 4,
    parameter int NUM_STEPS  = 16,
    parameter int FREQ_BITS  = 16,
    parameter int SI_W       = $clog2(NUM_STEPS),
    parameter int VI_W       = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1
)(
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            run,
    input  logic [TIME_W-1:0]               step_period,
    input  logic [TIME_W-1:0]               gate_len,
    input  logic [SI_W-1:0]                 last_step,
`ifdef STEP_SEQ_SWING_EN
    input  logic [TIME_W-1:0]               swing,
`endif
    input  logic                            wr_en,
    input  logic [VI_W-1:0]                 wr_voice,
    input  logic [SI_W-1:0]                 wr_step,
    input  logic [FREQ_BITS-1:0]            wr_freq,
    input  logic                            wr_on,
    output logic [NUM_VOICES*FREQ_BITS-1:0] tone_freq,
    output logic [NUM_VOICES-1:0]           gate,
    output logic [SI_W-1:0]                 step_idx,
    output logic                            step_strobe
);

    state_t                                 state;
    logic [FREQ_BITS-1:0]                   freq_mem [NUM_VOICES][NUM_STEPS];
    logic [NUM_VOICES-1:0][NUM_STEPS-1:0]   on_mem;
    logic [NUM_VOICES-1:0]                  on_lat;
    logic [SI_W-1:0]                        next_step;
    logic [SI_W-1:0]                        entry_step;
    logic [NUM_VOICES-1:0]                  cell_on;
    logic [FREQ_BITS-1:0]                   cell_freq [NUM_VOICES];
    logic                                   wr_hit;
    logic                                   start;
    logic                                   step_end;
    logic                                   gate_on;

    // Writes to a voice index beyond NUM_VOICES (non power-of-two counts)
    // are dropped.
    assign wr_hit = wr_en && (int'(wr_voice) < NUM_VOICES);

    // Frequency words keep their contents through reset.
    always_ff @(posedge clk) begin
        if (wr_hit) begin
            freq_mem[wr_voice][wr_step] <= wr_freq;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            on_mem <= '0;
        end else if (wr_hit) begin
            on_mem[wr_voice][wr_step] <= wr_on;
        end
    end

    // Cells are read combinationally at the boundary edge, so a write landing
    // on the same edge is seen only on the next visit to that step.
    always_comb begin
        if ((step_idx >= last_step) || (step_idx == SI_W'(NUM_STEPS - 1))) begin
            next_step = '0;
        end else begin
            next_step = step_idx + SI_W'(1);
        end
        entry_step = (state == IDLE) ? '0 : next_step;
        for (int v = 0; v < NUM_VOICES; v++) begin
            cell_on[v]   = on_mem[v][entry_step];
            cell_freq[v] = freq_mem[v][entry_step];
        end
    end

    assign start = run && ((state == IDLE) || step_end);

    seq_step_timer u_timer (
        .clk         (clk),
        .rst         (rst),
        .clear       (!run),
        .start       (start),
        .count       (state == PLAY),
        .step_period (step_period),
        .gate_len    (gate_len),
`ifdef STEP_SEQ_SWING_EN
        .step_odd    (entry_step[0]),
        .swing       (swing),
`endif
        .step_end    (step_end),
        .gate_on     (gate_on)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            gate        <= '0;
            tone_freq   <= '0;
            step_idx    <= '0;
            step_strobe <= 1'b0;
            on_lat      <= '0;
        end else if (!run) begin
            state       <= IDLE;
            gate        <= '0;
            step_idx    <= '0;
            step_strobe <= 1'b0;
        end else if (start) begin
            // Step entry: voices that are off keep their last pitch so the
            // release tail does not jump.
            state       <= PLAY;
            step_strobe <= 1'b1;
            step_idx    <= entry_step;
            on_lat      <= cell_on;
            gate        <= cell_on & {NUM_VOICES{gate_on}};
            for (int v = 0; v < NUM_VOICES; v++) begin
                if (cell_on[v]) begin
                    tone_freq[v*FREQ_BITS +: FREQ_BITS] <= cell_freq[v];
                end
            end
        end else begin
            step_strobe <= 1'b0;
            gate        <= on_lat & {NUM_VOICES{gate_on}};
        end
    end

endmodule

// File: tb/tb_step_sequencer.sv
// -----------------------------------------------------------------------------
// tb_step_sequencer
// Self-checking bench for step_sequencer with default parameters. Swing
// checks are included when STEP_SEQ_SWING_EN is defined.
// -----------------------------------------------------------------------------
module tb_step_sequencer;

    localparam int NV = 4;
    localparam int NS = 16;
    localparam int FB = 16;
    localparam int SI = 4;
    localparam int VI = 2;

    logic           clk = 1'b0;
    logic           rst;
    logic           run;
    logic [23:0]    step_period;
    logic [23:0]    gate_len;
    logic [SI-1:0]  last_step;
`ifdef STEP_SEQ_SWING_EN
    logic [23:0]    swing;
`endif
    logic           wr_en;
    logic [VI-1:0]  wr_voice;
    logic [SI-1:0]  wr_step;
    logic [FB-1:0]  wr_freq;
    logic           wr_on;
    logic [NV*FB-1:0] tone_freq;
    logic [NV-1:0]  gate;
    logic [SI-1:0]  step_idx;
    logic           step_strobe;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    step_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .run         (run),
        .step_period (step_period),
        .gate_len    (gate_len),
        .last_step   (last_step),
`ifdef STEP_SEQ_SWING_EN
        .swing       (swing),
`endif
        .wr_en       (wr_en),
        .wr_voice    (wr_voice),
        .wr_step     (wr_step),
        .wr_freq     (wr_freq),
        .wr_on       (wr_on),
        .tone_freq   (tone_freq),
        .gate        (gate),
        .step_idx    (step_idx),
        .step_strobe (step_strobe)
    );

    typedef struct {
        int period;
        int glen;
        int last;
        int exp_len;
        int exp_gate;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [FB-1:0] tone(input int v);
        return tone_freq[v*FB +: FB];
    endfunction

    task automatic write_cell(input int v, input int s, input logic [FB-1:0] f, input logic on);
        wr_en    = 1'b1;
        wr_voice = VI'(v);
        wr_step  = SI'(s);
        wr_freq  = f;
        wr_on    = on;
        tick();
        wr_en    = 1'b0;
    endtask

    // Called on a strobe cycle; returns at the next strobe cycle (bounded).
    task automatic measure_step(output int len, output int ghi, output int idx);
        idx = int'(step_idx);
        len = 0;
        ghi = 0;
        do begin
            if (gate[0]) ghi++;
            len++;
            tick();
        end while (!step_strobe && len < 200);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int len, ghi, idx;

        vecs[0] = '{10,  4, 3, 10, 4};
        vecs[1] = '{10, 50, 3, 10, 9};
        vecs[2] = '{ 1,  5, 1,  2, 1};
        vecs[3] = '{ 0,  0, 2,  2, 0};
        vecs[4] = '{ 6,  6, 0,  6, 5};
        vecs[5] = '{ 7,  1, 3,  7, 1};

        rst         = 1'b1;
        run         = 1'b0;
        step_period = 24'd10;
        gate_len    = 24'd4;
        last_step   = SI'(3);
`ifdef STEP_SEQ_SWING_EN
        swing       = 24'd0;
`endif
        wr_en       = 1'b0;
        wr_voice    = '0;
        wr_step     = '0;
        wr_freq     = '0;
        wr_on       = 1'b0;
        repeat (3) tick();
        rst = 1'b0;

        // Reset values and idle behaviour
        check("rst_gate", gate, 0);
        check("rst_tone", tone_freq, 0);
        check("rst_idx", step_idx, 0);
        check("rst_strobe", step_strobe, 0);
        for (int c = 0; c < 20; c++) begin
            tick();
            check($sformatf("idle_ctl c%0d", c), {gate, step_strobe, step_idx}, 0);
            check($sformatf("idle_tone c%0d", c), tone_freq, 0);
        end

        for (int s = 0; s < 4; s++) write_cell(0, s, 16'h4184, 1'b1);

        // Table-driven timing vectors on voice 0
        for (int i = 0; i < 6; i++) begin
            step_period = 24'(vecs[i].period);
            gate_len    = 24'(vecs[i].glen);
            last_step   = SI'(vecs[i].last);
            run = 1'b1;
            tick();
            check($sformatf("start_strobe v%0d", i), step_strobe, 1);
            check($sformatf("start_idx v%0d", i), step_idx, 0);
            check($sformatf("start_gate0 v%0d", i), gate[0], vecs[i].exp_gate > 0);
            check($sformatf("start_tone0 v%0d", i), tone(0), 16'h4184);
            for (int k = 0; k <= vecs[i].last + 1; k++) begin
                measure_step(len, ghi, idx);
                check($sformatf("idx v%0d k%0d", i, k), idx, k % (vecs[i].last + 1));
                check($sformatf("len v%0d k%0d", i, k), len, vecs[i].exp_len);
                check($sformatf("gate_cyc v%0d k%0d", i, k), ghi, vecs[i].exp_gate);
            end
            run = 1'b0;
            tick();
            check($sformatf("stop_gate v%0d", i), gate, 0);
            check($sformatf("stop_idx v%0d", i), step_idx, 0);
            tick();
        end

        // Voice 1: note-off step keeps the previous pitch with gate low
        write_cell(1, 0, 16'h2000, 1'b1);
        write_cell(1, 1, 16'h1000, 1'b0);
        write_cell(1, 2, 16'h3000, 1'b1);
        step_period = 24'd10;
        gate_len    = 24'd4;
        last_step   = SI'(2);
        run = 1'b1;
        tick();
        check("v1_s0_tone", tone(1), 16'h2000);
        check("v1_s0_gate", gate[1], 1);
        measure_step(len, ghi, idx);
        for (int c = 0; c < 10; c++) begin
            check($sformatf("v1_s1_gate c%0d", c), gate[1], 0);
            check($sformatf("v1_s1_tone c%0d", c), tone(1), 16'h2000);
            tick();
        end
        check("v1_s2_strobe", step_strobe, 1);
        check("v1_s2_idx", step_idx, 2);
        check("v1_s2_tone", tone(1), 16'h3000);
        check("v1_s2_gate", gate[1], 1);

        // Stop mid step 2, then restart from step 0
        repeat (3) tick();
        run = 1'b0;
        tick();
        check("midstop_gate", gate, 0);
        check("midstop_idx", step_idx, 0);
        check("midstop_strobe", step_strobe, 0);
        tick();
        run = 1'b1;
        tick();
        check("restart_strobe", step_strobe, 1);
        check("restart_idx", step_idx, 0);

        // Write to step 1 on the very edge that enters step 1: old cell used
        repeat (9) tick();
        wr_en    = 1'b1;
        wr_voice = VI'(0);
        wr_step  = SI'(1);
        wr_freq  = 16'h5555;
        wr_on    = 1'b1;
        tick();
        wr_en = 1'b0;
        check("bwr_strobe", step_strobe, 1);
        check("bwr_idx", step_idx, 1);
        check("bwr_old_tone", tone(0), 16'h4184);
        measure_step(len, ghi, idx);
        measure_step(len, ghi, idx);
        measure_step(len, ghi, idx);
        check("bwr_revisit_idx", step_idx, 1);
        check("bwr_new_tone", tone(0), 16'h5555);
        run = 1'b0;
        repeat (2) tick();

`ifdef STEP_SEQ_SWING_EN
        // Swing: even steps P+S, odd steps P-S, S clamped to P/2-1
        last_step = SI'(3);
        swing = 24'd3;
        run = 1'b1;
        tick();
        for (int k = 0; k < 4; k++) begin
            measure_step(len, ghi, idx);
            check($sformatf("swing3_len k%0d", k), len, (k % 2 == 0) ? 13 : 7);
            check($sformatf("swing3_gate k%0d", k), ghi, 4);
        end
        run = 1'b0;
        repeat (2) tick();
        swing = 24'd20;
        run = 1'b1;
        tick();
        for (int k = 0; k < 2; k++) begin
            measure_step(len, ghi, idx);
            check($sformatf("swing20_len k%0d", k), len, (k % 2 == 0) ? 14 : 6);
        end
        run = 1'b0;
        swing = 24'd0;
        repeat (2) tick();
`endif

        // Reset in the middle of play
        run = 1'b1;
        repeat (15) tick();
        rst = 1'b1;
        run = 1'b0;
        tick();
        check("midrst_gate", gate, 0);
        check("midrst_tone", tone_freq, 0);
        check("midrst_idx", step_idx, 0);
        check("midrst_strobe", step_strobe, 0);
        rst = 1'b0;
        tick();
        // All on bits were cleared: a new run strobes but opens no gate
        run = 1'b1;
        tick();
        check("postrst_strobe", step_strobe, 1);
        check("postrst_gate", gate, 0);
        check("postrst_tone", tone_freq, 0);
        run = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
